// File: rtl/data_path_muxs_pkg.sv
// Shared datapath types: word/register widths, writeback source select and MEM-stage FSM states.
package data_path_muxs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'd0,
    MTR_LOAD = 2'd1,
    MTR_LINK = 2'd2,
    MTR_IMM  = 2'd3
  } mem_to_reg_mux_selection;

  // Writeback source loaded into the MEM/WB register for a bubble.
  localparam mem_to_reg_mux_selection MTR_DEFAULT = MTR_ALU;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2
  } mem_fsm_t;

endpackage

// File: rtl/dmem_req_fsm.sv
// Dcache request sequencer: holds the request until dhit, then parks in HELD until the
// pipeline retires the instruction, so a finished access is never reissued.
module dmem_req_fsm
  import data_path_muxs_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ren_i,
  input  logic              wen_i,
  input  logic              enable_i,
  input  logic              dhit_i,
  input  logic [WORD_W-1:0] dmemload_i,
  output logic              dREN_o,
  output logic              dWEN_o,
  output logic              mem_stall_o,
  output logic [WORD_W-1:0] load_val_o
);

  mem_fsm_t          state_q, state_d;
  logic [WORD_W-1:0] load_buf_q, load_buf_d;
  logic              memop;
  logic              active;

  assign memop = ren_i | wen_i;
  // Reset gates the request combinationally so it drops without waiting for a clock edge.
  assign active = (state_q != HELD) && !RST;

  assign dWEN_o      = wen_i & active;
  assign dREN_o      = ren_i & ~wen_i & active;
  assign mem_stall_o = memop & ~dhit_i & active;
  assign load_val_o  = dhit_i ? dmemload_i : load_buf_q;

  always_comb begin
    state_d    = state_q;
    load_buf_d = load_buf_q;
    if (dhit_i && ren_i && !wen_i) begin
      load_buf_d = dmemload_i;
    end
    unique case (state_q)
      IDLE: begin
        if (memop && !dhit_i) begin
          state_d = WAIT;
        end else if (memop && dhit_i && !enable_i) begin
          state_d = HELD;
        end
      end
      WAIT: begin
        if (dhit_i) begin
          state_d = enable_i ? IDLE : HELD;
        end
      end
      HELD: begin
        if (enable_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      load_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      load_buf_q <= load_buf_d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register: dcache handshake, writeback register with
// stall/flush priority, sticky halt and a saturating dcache-wait counter.
module mem_wb_stage
  import data_path_muxs_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    enable_MEM_WB,
  input  logic                    flush_MEM_WB,
  input  logic                    dmemREN_EX_MEM,
  input  logic                    dmemWEN_EX_MEM,
  input  logic [WORD_W-1:0]       dmemaddr_EX_MEM,
  input  logic [WORD_W-1:0]       dmemstore_EX_MEM,
  input  logic [WORD_W-1:0]       result_EX_MEM,
  input  logic [WORD_W-1:0]       next_imemaddr_EX_MEM,
  input  logic                    WEN_EX_MEM,
  input  logic [REG_AW-1:0]       wsel_EX_MEM,
  input  mem_to_reg_mux_selection mem_to_reg_EX_MEM,
  input  logic                    halt_EX_MEM,
  input  logic                    dhit,
  input  logic [WORD_W-1:0]       dmemload,
  output logic                    dREN,
  output logic                    dWEN,
  output logic [WORD_W-1:0]       daddr,
  output logic [WORD_W-1:0]       dstore,
  output logic                    mem_stall,
  output logic                    WEN_MEM_WB,
  output logic [REG_AW-1:0]       wsel_MEM_WB,
  output mem_to_reg_mux_selection mem_to_reg_MEM_WB,
  output logic [WORD_W-1:0]       result_MEM_WB,
  output logic [WORD_W-1:0]       dmemload_MEM_WB,
  output logic [WORD_W-1:0]       next_imemaddr_MEM_WB,
  output logic                    halt_MEM_WB,
  output logic [CNT_W-1:0]        dwait_cnt
);

  logic [WORD_W-1:0]       load_val;
  logic                    wen_q, wen_d;
  logic [REG_AW-1:0]       wsel_q, wsel_d;
  mem_to_reg_mux_selection mtr_q, mtr_d;
  logic [WORD_W-1:0]       result_q, result_d;
  logic [WORD_W-1:0]       dload_q, dload_d;
  logic [WORD_W-1:0]       link_q, link_d;
  logic                    halt_q, halt_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  dmem_req_fsm #(.WORD_W(WORD_W)) u_req (
    .CLK        (CLK),
    .RST        (RST),
    .ren_i      (dmemREN_EX_MEM),
    .wen_i      (dmemWEN_EX_MEM),
    .enable_i   (enable_MEM_WB),
    .dhit_i     (dhit),
    .dmemload_i (dmemload),
    .dREN_o     (dREN),
    .dWEN_o     (dWEN),
    .mem_stall_o(mem_stall),
    .load_val_o (load_val)
  );

  assign daddr  = dmemaddr_EX_MEM;
  assign dstore = dmemstore_EX_MEM;

  // A stall overrides the hazard unit's enable; flush only acts on a cycle that would load.
  always_comb begin
    wen_d    = wen_q;
    wsel_d   = wsel_q;
    mtr_d    = mtr_q;
    result_d = result_q;
    dload_d  = dload_q;
    link_d   = link_q;
    if (mem_stall) begin
      wen_d = wen_q;
    end else if (enable_MEM_WB && flush_MEM_WB) begin
      wen_d    = 1'b0;
      wsel_d   = '0;
      mtr_d    = MTR_DEFAULT;
      result_d = '0;
      dload_d  = '0;
      link_d   = '0;
    end else if (enable_MEM_WB) begin
      wen_d    = WEN_EX_MEM;
      wsel_d   = wsel_EX_MEM;
      mtr_d    = mem_to_reg_EX_MEM;
      result_d = result_EX_MEM;
      dload_d  = load_val;
      link_d   = next_imemaddr_EX_MEM;
    end
    halt_d = halt_q | (enable_MEM_WB & ~flush_MEM_WB & ~mem_stall & halt_EX_MEM);
    cnt_d  = (mem_stall && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wen_q    <= 1'b0;
      wsel_q   <= '0;
      mtr_q    <= MTR_DEFAULT;
      result_q <= '0;
      dload_q  <= '0;
      link_q   <= '0;
      halt_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wen_q    <= wen_d;
      wsel_q   <= wsel_d;
      mtr_q    <= mtr_d;
      result_q <= result_d;
      dload_q  <= dload_d;
      link_q   <= link_d;
      halt_q   <= halt_d;
      cnt_q    <= cnt_d;
    end
  end

  // The EX stage must never present a load and a store together.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(dmemREN_EX_MEM && dmemWEN_EX_MEM));
    end
  end

  assign WEN_MEM_WB           = wen_q;
  assign wsel_MEM_WB          = wsel_q;
  assign mem_to_reg_MEM_WB    = mtr_q;
  assign result_MEM_WB        = result_q;
  assign dmemload_MEM_WB      = dload_q;
  assign next_imemaddr_MEM_WB = link_q;
  assign halt_MEM_WB          = halt_q;
  assign dwait_cnt            = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, load/store handshakes, HELD buffering, flush,
// sticky halt, counter saturation and reset during an outstanding access.
module tb_mem_wb_stage;
  import data_path_muxs_pkg::*;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic                    enable_MEM_WB, flush_MEM_WB;
  logic                    dmemREN_EX_MEM, dmemWEN_EX_MEM;
  logic [WORD_W-1:0]       dmemaddr_EX_MEM, dmemstore_EX_MEM, result_EX_MEM, next_imemaddr_EX_MEM;
  logic                    WEN_EX_MEM;
  logic [REG_AW-1:0]       wsel_EX_MEM;
  mem_to_reg_mux_selection mem_to_reg_EX_MEM;
  logic                    halt_EX_MEM, dhit;
  logic [WORD_W-1:0]       dmemload;
  logic                    dREN, dWEN, mem_stall, WEN_MEM_WB, halt_MEM_WB;
  logic [WORD_W-1:0]       daddr, dstore, result_MEM_WB, dmemload_MEM_WB, next_imemaddr_MEM_WB;
  logic [REG_AW-1:0]       wsel_MEM_WB;
  mem_to_reg_mux_selection mem_to_reg_MEM_WB;
  logic [CNT_W-1:0]        dwait_cnt;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.WORD_W(WORD_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .enable_MEM_WB(enable_MEM_WB), .flush_MEM_WB(flush_MEM_WB),
    .dmemREN_EX_MEM(dmemREN_EX_MEM), .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
    .dmemaddr_EX_MEM(dmemaddr_EX_MEM), .dmemstore_EX_MEM(dmemstore_EX_MEM),
    .result_EX_MEM(result_EX_MEM), .next_imemaddr_EX_MEM(next_imemaddr_EX_MEM),
    .WEN_EX_MEM(WEN_EX_MEM), .wsel_EX_MEM(wsel_EX_MEM),
    .mem_to_reg_EX_MEM(mem_to_reg_EX_MEM), .halt_EX_MEM(halt_EX_MEM),
    .dhit(dhit), .dmemload(dmemload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .mem_stall(mem_stall),
    .WEN_MEM_WB(WEN_MEM_WB), .wsel_MEM_WB(wsel_MEM_WB), .mem_to_reg_MEM_WB(mem_to_reg_MEM_WB),
    .result_MEM_WB(result_MEM_WB), .dmemload_MEM_WB(dmemload_MEM_WB),
    .next_imemaddr_MEM_WB(next_imemaddr_MEM_WB), .halt_MEM_WB(halt_MEM_WB),
    .dwait_cnt(dwait_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; enable_MEM_WB = 1'b1; flush_MEM_WB = 1'b0;
    dmemREN_EX_MEM = 1'b1; dmemWEN_EX_MEM = 1'b0;
    dmemaddr_EX_MEM = 32'h100; dmemstore_EX_MEM = '0;
    result_EX_MEM = 32'h100; next_imemaddr_EX_MEM = 32'h8;
    WEN_EX_MEM = 1'b1; wsel_EX_MEM = 5'd3; mem_to_reg_EX_MEM = MTR_LOAD;
    halt_EX_MEM = 1'b0; dhit = 1'b0; dmemload = '0;

    // Reset held with a load presented
    #3;
    checkOutput("rst_dREN", 32'(dREN), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    applyStimulus(2);
    checkOutput("rst_dREN_held", 32'(dREN), 32'd0);
    checkOutput("rst_WEN", 32'(WEN_MEM_WB), 32'd0);
    checkOutput("rst_dload", dmemload_MEM_WB, 32'd0);
    checkOutput("rst_halt", 32'(halt_MEM_WB), 32'd0);
    checkOutput("rst_cnt", 32'(dwait_cnt), 32'd0);

    // Load 0x100: two stall cycles, dhit on the third
    RST = 1'b0; #1;
    checkOutput("ld_dREN_c1", 32'(dREN), 32'd1);
    checkOutput("ld_daddr", daddr, 32'h100);
    checkOutput("ld_stall_c1", 32'(mem_stall), 32'd1);
    applyStimulus(1);
    checkOutput("ld_dREN_c2", 32'(dREN), 32'd1);
    checkOutput("ld_stall_c2", 32'(mem_stall), 32'd1);
    applyStimulus(1);
    dhit = 1'b1; dmemload = 32'hDEADBEEF; #1;
    checkOutput("ld_stall_c3", 32'(mem_stall), 32'd0);
    applyStimulus(1);
    checkOutput("ld_dload", dmemload_MEM_WB, 32'hDEADBEEF);
    checkOutput("ld_cnt", 32'(dwait_cnt), 32'd2);
    checkOutput("ld_wsel", 32'(wsel_MEM_WB), 32'd3);
    checkOutput("ld_mtr", 32'(mem_to_reg_MEM_WB), 32'(MTR_LOAD));

    // Store completes while the pipeline is held for two more cycles
    dmemREN_EX_MEM = 1'b0; dmemWEN_EX_MEM = 1'b1; dmemaddr_EX_MEM = 32'h200;
    dmemstore_EX_MEM = 32'hCAFEF00D; result_EX_MEM = 32'h200; WEN_EX_MEM = 1'b0;
    mem_to_reg_EX_MEM = MTR_ALU; enable_MEM_WB = 1'b0; dhit = 1'b1; #1;
    checkOutput("st_dWEN", 32'(dWEN), 32'd1);
    checkOutput("st_dREN", 32'(dREN), 32'd0);
    checkOutput("st_dstore", dstore, 32'hCAFEF00D);
    applyStimulus(1);
    dhit = 1'b0; #1;
    checkOutput("st_held_dWEN1", 32'(dWEN), 32'd0);
    checkOutput("st_held_stall", 32'(mem_stall), 32'd0);
    checkOutput("st_held_hold", dmemload_MEM_WB, 32'hDEADBEEF);
    applyStimulus(1);
    checkOutput("st_held_dWEN2", 32'(dWEN), 32'd0);
    enable_MEM_WB = 1'b1;
    applyStimulus(1);
    checkOutput("st_result", result_MEM_WB, 32'h200);
    checkOutput("st_WEN", 32'(WEN_MEM_WB), 32'd0);
    checkOutput("st_cnt", 32'(dwait_cnt), 32'd2);

    // Load finishes in HELD; retirement must use the buffered value, not the bus
    dmemWEN_EX_MEM = 1'b0; dmemREN_EX_MEM = 1'b1; dmemaddr_EX_MEM = 32'h300;
    WEN_EX_MEM = 1'b1; wsel_EX_MEM = 5'd7; mem_to_reg_EX_MEM = MTR_LOAD;
    enable_MEM_WB = 1'b0; dhit = 1'b1; dmemload = 32'h12345678; #1;
    checkOutput("hb_dREN", 32'(dREN), 32'd1);
    applyStimulus(1);
    dhit = 1'b0; dmemload = 32'hBADBAD00; enable_MEM_WB = 1'b1; #1;
    checkOutput("hb_dREN_held", 32'(dREN), 32'd0);
    applyStimulus(1);
    checkOutput("hb_dload", dmemload_MEM_WB, 32'h12345678);
    checkOutput("hb_wsel", 32'(wsel_MEM_WB), 32'd7);

    // Flush on an ALU op with a halt: bubble, halt not set
    dmemREN_EX_MEM = 1'b0; WEN_EX_MEM = 1'b1; wsel_EX_MEM = 5'd5; result_EX_MEM = 32'hAAAA;
    mem_to_reg_EX_MEM = MTR_LINK; halt_EX_MEM = 1'b1; flush_MEM_WB = 1'b1;
    applyStimulus(1);
    checkOutput("fl_WEN", 32'(WEN_MEM_WB), 32'd0);
    checkOutput("fl_wsel", 32'(wsel_MEM_WB), 32'd0);
    checkOutput("fl_result", result_MEM_WB, 32'd0);
    checkOutput("fl_mtr", 32'(mem_to_reg_MEM_WB), 32'(MTR_ALU));
    checkOutput("fl_halt", 32'(halt_MEM_WB), 32'd0);

    // Halt loads and stays sticky
    flush_MEM_WB = 1'b0; result_EX_MEM = 32'h55; next_imemaddr_EX_MEM = 32'h44; wsel_EX_MEM = 5'd31;
    applyStimulus(1);
    checkOutput("ht_set", 32'(halt_MEM_WB), 32'd1);
    checkOutput("ht_link", next_imemaddr_MEM_WB, 32'h44);
    halt_EX_MEM = 1'b0;
    applyStimulus(1);
    checkOutput("ht_sticky", 32'(halt_MEM_WB), 32'd1);

    // Long stall: register holds despite enable, counter saturates
    dmemREN_EX_MEM = 1'b1; dmemaddr_EX_MEM = 32'h400; result_EX_MEM = 32'h66; wsel_EX_MEM = 5'd9;
    applyStimulus(20);
    checkOutput("sat_cnt", 32'(dwait_cnt), 32'd15);
    checkOutput("sat_hold", result_MEM_WB, 32'h55);
    checkOutput("sat_stall", 32'(mem_stall), 32'd1);
    dhit = 1'b1; dmemload = 32'h0F0F0F0F;
    applyStimulus(1);
    checkOutput("sat_dload", dmemload_MEM_WB, 32'h0F0F0F0F);
    checkOutput("sat_cnt_after", 32'(dwait_cnt), 32'd15);
    checkOutput("sat_halt", 32'(halt_MEM_WB), 32'd1);

    // Reset during an outstanding load, then re-request
    dhit = 1'b0; dmemaddr_EX_MEM = 32'h500;
    applyStimulus(1);
    RST = 1'b1; #1;
    checkOutput("mr_dREN", 32'(dREN), 32'd0);
    checkOutput("mr_halt", 32'(halt_MEM_WB), 32'd0);
    checkOutput("mr_cnt", 32'(dwait_cnt), 32'd0);
    applyStimulus(1);
    RST = 1'b0; #1;
    checkOutput("mr_rereq", 32'(dREN), 32'd1);
    checkOutput("mr_stall", 32'(mem_stall), 32'd1);
    applyStimulus(1);
    checkOutput("mr_cnt_run", 32'(dwait_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
